// File: rtl/div_operand_queue.sv
// Operand FIFO and registered response stage around a combinational 16/8 divider.
// Optional saturating divide-by-zero counter: define DIVQ_ERR_CNT_EN.
module div_operand_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [7:0]       in_b,
   output logic [15:0]      div_a,
   output logic [7:0]       div_b,
   input  logic [15:0]      div_result,
   input  logic [15:0]      div_odd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_result,
   output logic [15:0]      out_odd,
   output logic             out_divzero,
   output logic [PTR_W:0]   count
`ifdef DIVQ_ERR_CNT_EN
   ,
   output logic [7:0]       err_cnt
`endif
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [15:0]    r_mem_a [DEPTH];
   logic [7:0]     r_mem_b [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0] r_count;
   logic           r_out_valid;
   logic [15:0]    r_out_result;
   logic [15:0]    r_out_odd;
   logic           r_out_divzero;

   logic           w_in_ready;
   logic           w_not_empty;
   logic           w_push;
   logic           w_load;
   logic [15:0]    w_head_a;
   logic [7:0]     w_head_b;

   // Handshake decode; in_ready depends only on registered occupancy.
   always_comb begin
      w_in_ready  = (r_count != FULL_CNT);
      w_not_empty = (r_count != '0);
      w_push      = in_valid && w_in_ready;
      w_load      = w_not_empty && (!r_out_valid || out_ready);
      w_head_a    = w_not_empty ? r_mem_a[r_rd_ptr] : 16'd0;
      w_head_b    = w_not_empty ? r_mem_b[r_rd_ptr] : 8'd0;
   end

   // Operand storage written at the tail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_a[i] <= '0;
            r_mem_b[i] <= '0;
         end
      end else if (w_push) begin
         r_mem_a[r_wr_ptr] <= in_a;
         r_mem_b[r_wr_ptr] <= in_b;
      end
   end

   // Pointers wrap naturally; count separates full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_load)
            r_count <= r_count + 1'b1;
         else if (!w_push && w_load)
            r_count <= r_count - 1'b1;
      end
   end

   // Response register captures divider outputs for the popped head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid   <= 1'b0;
         r_out_result  <= '0;
         r_out_odd     <= '0;
         r_out_divzero <= 1'b0;
      end else if (w_load) begin
         r_out_valid   <= 1'b1;
         r_out_result  <= div_result;
         r_out_odd     <= div_odd;
         r_out_divzero <= (w_head_b == 8'd0);
      end else if (r_out_valid && out_ready) begin
         r_out_valid   <= 1'b0;
      end
   end

`ifdef DIVQ_ERR_CNT_EN
   logic [7:0] r_err_cnt;

   // Saturating count of responses produced from a zero divisor.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err_cnt <= '0;
      else if (w_load && (w_head_b == 8'd0) && (r_err_cnt != 8'hFF))
         r_err_cnt <= r_err_cnt + 8'd1;
   end

   assign err_cnt = r_err_cnt;
`endif

   assign in_ready    = w_in_ready;
   assign div_a       = w_head_a;
   assign div_b       = w_head_b;
   assign out_valid   = r_out_valid;
   assign out_result  = r_out_result;
   assign out_odd     = r_out_odd;
   assign out_divzero = r_out_divzero;
   assign count       = r_count;

endmodule

// File: doc/div_operand_queue.md
Name: div_operand_queue

Overview:
- Buffered issue/collect stage wrapped around the combinational 16-by-8 divider (dividend A, divisor B, quotient result, remainder odd).
- Accepts operand pairs over a valid/ready interface into a DEPTH-entry FIFO.
- Drives the FIFO head onto the divider inputs and captures the divider outputs into a registered response with valid/ready.
- Decouples the divider's long combinational path from the upstream and downstream handshakes.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept.
- in_a  in  16  dividend.
- in_b  in  8  divisor.
- div_a  out  16  to divider A; FIFO head dividend.
- div_b  out  8  to divider B; FIFO head divisor.
- div_result  in  16  from divider result (quotient).
- div_odd  in  16  from divider odd (remainder).
- out_valid  out  1  response held.
- out_ready  in  1  downstream accepts.
- out_result  out  16  registered quotient.
- out_odd  out  16  registered remainder.
- out_divzero  out  1  response came from B==0.
- count  out  PTR_W+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers = 0, count = 0, in_ready = 1.
  - out_valid = 0; out_result, out_odd = 0; out_divzero = 0.
  - div_a, div_b = 0 while the FIFO is empty.
- Push: in_valid && in_ready at a rising edge writes {in_a, in_b} at the write pointer. in_ready = (count != DEPTH) and is registered-derived, with no path from out_ready.
- Head: div_a/div_b combinationally show the head entry when count > 0, else 0.
- Load condition: load = (count > 0) && (!out_valid || out_ready).
  - On load: pop the head; out_result <= div_result; out_odd <= div_odd; out_divzero <= (div_b == 0); out_valid <= 1.
  - Else if out_valid && out_ready: out_valid <= 0 (data regs hold).
- Latency: a pair pushed at edge N appears with out_valid = 1 after edge N+1, if the FIFO was empty and the output was free.
- Throughput: 1 response per cycle with out_ready held high.
- Simultaneous push and pop: count unchanged; both pointers advance. Push into an empty FIFO is not bypassed to the output in the same cycle.
- Full: in_ready = 0; in_valid is ignored and nothing is overwritten. in_ready returns high the cycle after a pop.
- Empty with out_ready high: out_valid drops; no spurious load.
- Pointer wrap: pointers wrap modulo DEPTH; count distinguishes full from empty.
- Divide-by-zero: the block does not alter divider outputs. It forwards result = 0, odd = A as the divider gives them, and sets out_divzero.
- out_* are stable while out_valid && !out_ready.
- Reset mid-operation: all FIFO contents and any pending response are discarded immediately; no response issues after rst_n releases.

Optional Feature:
- Macro: DIVQ_ERR_CNT_EN.
- Defined:
  - Extra output err_cnt [7:0], reset 0.
  - Increments on each load with div_b == 0.
  - Saturates at 8'hFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Push A=100, B=7 into an empty queue with out_ready=1 -> out_valid one cycle later; out_result=14, out_odd=2, out_divzero=0.
- Push A=16'hFFFF, B=8'hFF, then A=16'h0001, B=8'h02 back-to-back -> consecutive responses (257,0) then (0,1), in order, with no gap.
- Push A=16'h1234, B=0 -> out_result=0, out_odd=16'h1234, out_divzero=1; with DIVQ_ERR_CNT_EN, err_cnt=1. Repeat 300 times -> err_cnt=8'hFF.
- Hold out_ready=0 and push 5 pairs -> first loads the output, next 4 fill the FIFO, count=4, in_ready=0, 6th offer is not accepted. Then raise out_ready -> all 5 responses drain in order, one per cycle.
- Continuous push/pop with out_ready=1 for 20 operations -> count stays at most 1 and pointers wrap correctly past DEPTH; all quotients and remainders match a reference model.
- Assert rst_n low with count=3 and out_valid=1 -> out_valid=0, count=0, in_ready=1 immediately. After release, no stale responses appear.
